// File: rtl/apb_i2s_pkg.sv
// rtl/apb_i2s_pkg.sv - shared constants for the APB I2S transmitter
// Purpose: register selectors, CTRL/STATUS bit positions and sample widths
//          used by apb_i2s_ctrl and its TX FIFO.
// Ports:   none (package).
package apb_i2s_pkg;

  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 2 * SAMPLE_W;

  // Register selector, taken from PADDR[3:2]
  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_CLKDIV = 2'd1,
    REG_TXDATA = 2'd2,
    REG_STATUS = 2'd3
  } reg_sel_e;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_CLR     = 1;

  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_UNDERRUN  = 2;
  localparam int ST_LEVEL_LSB = 4;

endpackage

// File: rtl/i2s_tx_fifo.sv
// rtl/i2s_tx_fifo.sv - synchronous TX FIFO for stereo sample words
// Purpose: show-ahead FIFO; rdata is the head word whenever empty=0.
// Ports:   clk, rst (async, active-high); push/wdata write side;
//          pop reads the head; clr empties the FIFO and beats push/pop;
//          full, empty, level report occupancy.
module i2s_tx_fifo
  import apb_i2s_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = WORD_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  // A push into a full FIFO is dropped even if a pop happens the same cycle.
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/apb_i2s_ctrl.sv
// rtl/apb_i2s_ctrl.sv - APB3 slave driving a Philips-format I2S master transmitter
// Purpose: register file (CTRL, CLKDIV, TXDATA, STATUS), TX FIFO, SCK divider,
//          frame counter and output shift register.
// Ports:   i_clk, i_rst (async, active-high); APB3 slave i_psel, i_penable,
//          i_pwrite, i_paddr, i_pwdata, o_prdata, o_pready, o_pslverr;
//          I2S outputs o_sck, o_ws (0=left), o_sd (MSB first).
module apb_i2s_ctrl
  import apb_i2s_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int APB_AW     = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_psel,
  input  logic              i_penable,
  input  logic              i_pwrite,
  input  logic [APB_AW-1:0] i_paddr,
  input  logic [31:0]       i_pwdata,
  output logic [31:0]       o_prdata,
  output logic              o_pready,
  output logic              o_pslverr,
  output logic              o_sck,
  output logic              o_ws,
  output logic              o_sd
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic              access;
  logic              wr;
  reg_sel_e          sel;
  logic              paddr_unused;

  logic              en;
  logic [7:0]        div;
  logic              underrun;

  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_clr;
  logic              fifo_full;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_rdata;
  logic [LW-1:0]     fifo_level;
  logic [3:0]        level_sat;
  logic              pop_ok;

  logic [7:0]        dcnt;
  logic [7:0]        div_cur;
  logic [4:0]        bcnt;
  logic [4:0]        bnext;
  logic              started;
  logic              tick;
  logic              fall;
  logic [WORD_W-1:0] hold;
  logic [WORD_W-1:0] sr;

  assign access       = i_psel && i_penable;
  assign wr           = access && i_pwrite;
  assign sel          = reg_sel_e'(i_paddr[3:2]);
  assign paddr_unused = ^{i_paddr[APB_AW-1:4], i_paddr[1:0]};

  assign fifo_clr  = wr && (sel == REG_CTRL) && i_pwdata[CTRL_CLR];
  assign fifo_push = wr && (sel == REG_TXDATA);

  assign tick  = en && (dcnt == div_cur);
  assign fall  = tick && o_sck;
  assign bnext = bcnt + 5'd1;
  // Slot 31 is the last right-channel slot: fetch the next frame's word there.
  assign fifo_pop = fall && (bnext == 5'd31);
  assign pop_ok   = !fifo_empty && !fifo_clr;

  assign level_sat = (32'(fifo_level) > 32'd15) ? 4'hF : 4'(fifo_level);

  i2s_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (WORD_W)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .clr   (fifo_clr),
    .wdata (i_pwdata),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign o_pready  = 1'b1;
  assign o_pslverr = fifo_push && fifo_full;

  always_comb begin
    o_prdata = '0;
    if (access) begin
      unique case (sel)
        REG_CTRL:   o_prdata[CTRL_EN] = en;
        REG_CLKDIV: o_prdata[7:0]     = div;
        REG_TXDATA: o_prdata          = '0;
        REG_STATUS: begin
          o_prdata[ST_EMPTY]                     = fifo_empty;
          o_prdata[ST_FULL]                      = fifo_full;
          o_prdata[ST_UNDERRUN]                  = underrun;
          o_prdata[ST_LEVEL_LSB+3:ST_LEVEL_LSB]  = level_sat;
        end
        default:    o_prdata = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      en       <= 1'b0;
      div      <= '0;
      underrun <= 1'b0;
    end else begin
      if (wr && (sel == REG_CTRL))   en  <= i_pwdata[CTRL_EN];
      if (wr && (sel == REG_CLKDIV)) div <= i_pwdata[7:0];
      // A new underrun beats a simultaneous W1C so no event is lost.
      if (fifo_pop && !pop_ok)
        underrun <= 1'b1;
      else if (wr && (sel == REG_STATUS) && i_pwdata[ST_UNDERRUN])
        underrun <= 1'b0;
    end
  end

  // Idle bit counter parks at 30 so the first falling edge after enable is the
  // fetch slot (31) and the next one starts the left channel. 'started' keeps
  // WS low during that lead-in slot.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      dcnt    <= '0;
      div_cur <= '0;
      o_sck   <= 1'b0;
      o_ws    <= 1'b0;
      o_sd    <= 1'b0;
      bcnt    <= 5'd30;
      started <= 1'b0;
      hold    <= '0;
      sr      <= '0;
    end else if (!en) begin
      dcnt    <= '0;
      div_cur <= div;
      o_sck   <= 1'b0;
      o_ws    <= 1'b0;
      o_sd    <= 1'b0;
      bcnt    <= 5'd30;
      started <= 1'b0;
      hold    <= '0;
      sr      <= '0;
    end else begin
      // DIV is sampled only at reload so a half-period is never cut short.
      if (tick) begin
        dcnt    <= '0;
        div_cur <= div;
        o_sck   <= ~o_sck;
      end else begin
        dcnt <= dcnt + 8'd1;
      end
      if (fall) begin
        bcnt    <= bnext;
        started <= 1'b1;
        o_ws    <= bnext[4] && started;
        // SD lags WS by one slot: slot 0 still carries the previous R LSB.
        o_sd    <= sr[WORD_W-1];
        if (bnext == 5'd0) sr <= hold;
        else               sr <= {sr[WORD_W-2:0], 1'b0};
        if (fifo_pop) hold <= pop_ok ? fifo_rdata : '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_i2s_ctrl.sv
// tb/tb_apb_i2s_ctrl.sv - self-checking bench for apb_i2s_ctrl
module tb_apb_i2s_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] paddr = '0, pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr, sck, ws, sd;

  always #5 clk = ~clk;

  apb_i2s_ctrl #(.FIFO_DEPTH(8), .APB_AW(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_psel(psel), .i_penable(penable),
    .i_pwrite(pwrite), .i_paddr(paddr), .i_pwdata(pwdata),
    .o_prdata(prdata), .o_pready(pready), .o_pslverr(pslverr),
    .o_sck(sck), .o_ws(ws), .o_sd(sd)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Behavioural I2S receiver: samples on SCK rise; a WS high->low step marks
  // the slot carrying the previous word's LSB, so the last 32 bits form a word.
  bit          rx_en = 1'b0;
  logic        psck, pws;
  int          since, per;
  logic [31:0] acc;
  logic [31:0] rxq[$];

  always @(negedge clk) begin
    if (!rx_en) begin
      psck = 1'b0; pws = 1'b0; since = 0; acc = '0;
      rxq.delete();
    end else begin
      since++;
      if (sck && !psck) begin
        per = since; since = 0;
        acc = {acc[30:0], sd};
        if (!ws && pws) rxq.push_back(acc);
        pws = ws;
      end
      psck = sck;
    end
  end

  function automatic logic [31:0] rxw(input int i);
    return (rxq.size() > i) ? rxq[i] : 32'hDEAD_BEEF;
  endfunction

  // Expected STATUS from the FIFO occupancy and the sticky underrun flag.
  function automatic logic [31:0] st(input int lvl, input bit und);
    logic [3:0] l4;
    l4 = (lvl > 15) ? 4'hF : lvl[3:0];
    return {24'b0, l4, 1'b0, und, lvl == 8, lvl == 0};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the access edge.
  task automatic apb(input bit w, input logic [31:0] a, input logic [31:0] d,
                     output logic [31:0] r, output bit e);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
    @(posedge clk); #1 penable = 1'b1;
    #3 r = prdata; e = pslverr;
    @(posedge clk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r; bit e;
    apb(1'b1, a, d, r, e);
  endtask

  task automatic rd_chk(input string n, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r; bit e;
    apb(1'b0, a, 32'h0, r, e);
    chk(n, r, exp);
  endtask

  task automatic wait_words(input int n, input int budget);
    int c = 0;
    do begin @(posedge clk); c++; end while (rxq.size() < n && c < budget);
    #1;
    chk("rx_wait", 32'(rxq.size() >= n), 32'd1);
  endtask

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] er;
    bit          ee;
  } vec_t;

  vec_t tv[$];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r, w;
    bit          e;
    int          dv, n, c;
    logic [31:0] q[$];

    tv.push_back('{0, 32'h0,        32'h0,        32'h0,  0});
    tv.push_back('{0, 32'h4,        32'h0,        32'h0,  0});
    tv.push_back('{0, 32'hC,        32'h0,        32'h01, 0});
    tv.push_back('{0, 32'h8,        32'h0,        32'h0,  0});
    tv.push_back('{1, 32'h4,        32'hFFFF_FF37, 32'h0, 0});
    tv.push_back('{0, 32'h4,        32'h0,        32'h37, 0});
    tv.push_back('{0, 32'hFFF0_0004, 32'h0,       32'h37, 0});
    tv.push_back('{1, 32'h8,        32'h1234_5678, 32'h0, 0});
    tv.push_back('{0, 32'hC,        32'h0,        32'h10, 0});
    tv.push_back('{0, 32'h8,        32'h0,        32'h0,  0});
    tv.push_back('{1, 32'hC,        32'h0,        32'h0,  0});
    tv.push_back('{1, 32'hC,        32'hFFFF_FFFB, 32'h0, 0});
    tv.push_back('{0, 32'hC,        32'h0,        32'h10, 0});
    tv.push_back('{1, 32'h0,        32'h2,        32'h0,  0});
    tv.push_back('{0, 32'h0,        32'h0,        32'h0,  0});
    tv.push_back('{0, 32'hC,        32'h0,        32'h01, 0});
    tv.push_back('{1, 32'h4,        32'h0,        32'h0,  0});

    repeat (3) @(posedge clk);
    #1;
    chk("reset_pins", {29'b0, sck, ws, sd}, 32'h0);
    chk("reset_prdata", prdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (tv[i]) begin
      apb(tv[i].w, tv[i].a, tv[i].d, r, e);
      if (!tv[i].w) chk($sformatf("vec%0d_rd", i), r, tv[i].er);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(tv[i].ee));
    end

    // DIV=1 single word: SCK period 4, left then right sample MSB first
    wr(32'h4, 32'h1);
    wr(32'h8, 32'hA5A5_3C3C);
    rx_en = 1'b1;
    wr(32'h0, 32'h1);
    wait_words(2, 2000);
    chk("t2_word", rxw(0), 32'hA5A5_3C3C);
    chk("t2_zero_word", rxw(1), 32'h0);
    chk("t2_sck_period", 32'(per), 32'd4);
    wr(32'h0, 32'h0);
    rx_en = 1'b0;
    rd_chk("t2_status", 32'hC, st(0, 1'b1));
    wr(32'hC, 32'h4);
    rd_chk("t2_w1c", 32'hC, st(0, 1'b0));

    // Fill to FULL with EN=0, then overflow
    for (int i = 0; i < 8; i++) begin
      apb(1'b1, 32'h8, 32'h1000 + i, r, e);
      chk("t3_push_err", 32'(e), 32'h0);
    end
    rd_chk("t3_full", 32'hC, st(8, 1'b0));
    apb(1'b1, 32'h8, 32'hBAD0_BAD0, r, e);
    chk("t3_ovf_err", 32'(e), 32'h1);
    rd_chk("t3_full_after", 32'hC, st(8, 1'b0));
    wr(32'h0, 32'h2);
    rd_chk("t3_cleared", 32'hC, st(0, 1'b0));

    // Underrun with empty FIFO
    wr(32'h4, 32'h0);
    rx_en = 1'b1;
    wr(32'h0, 32'h1);
    wait_words(1, 500);
    chk("t4_zero_word", rxw(0), 32'h0);
    wr(32'h0, 32'h0);
    rx_en = 1'b0;
    rd_chk("t4_underrun", 32'hC, st(0, 1'b1));
    wr(32'hC, 32'h4);
    rd_chk("t4_w1c", 32'hC, st(0, 1'b0));

    // FIFO_CLR with data queued
    for (int i = 0; i < 3; i++) wr(32'h8, 32'h77 + i);
    rd_chk("t5_level3", 32'hC, st(3, 1'b0));
    wr(32'h0, 32'h2);
    rd_chk("t5_status", 32'hC, st(0, 1'b0));
    rd_chk("t5_ctrl", 32'h0, 32'h0);

    // Randomized pushes and transmission against a queue model
    for (int it = 0; it < 4; it++) begin
      dv = $urandom_range(0, 3);
      n  = $urandom_range(1, 10);
      q.delete();
      wr(32'h4, dv);
      for (int k = 0; k < n; k++) begin
        w = $urandom;
        apb(1'b1, 32'h8, w, r, e);
        chk("rnd_push_err", 32'(e), 32'(q.size() == 8));
        if (q.size() < 8) q.push_back(w);
      end
      rd_chk("rnd_status", 32'hC, st(q.size(), 1'b0));
      rx_en = 1'b1;
      wr(32'h0, 32'h1);
      wait_words(q.size() + 1, 64 * (dv + 1) * (q.size() + 4));
      for (int j = 0; j <= q.size(); j++)
        chk($sformatf("rnd%0d_word%0d", it, j), rxw(j), (j < q.size()) ? q[j] : 32'h0);
      chk("rnd_sck_period", 32'(per), 32'(2 * (dv + 1)));
      wr(32'h0, 32'h0);
      rx_en = 1'b0;
      rd_chk("rnd_underrun", 32'hC, st(0, 1'b1));
      wr(32'hC, 32'h4);
      rd_chk("rnd_w1c", 32'hC, st(0, 1'b0));
    end

    // Reset in the middle of a frame
    wr(32'h4, 32'h0);
    wr(32'h8, 32'hFFFF_FFFF);
    wr(32'h0, 32'h1);
    c = 0;
    do begin @(posedge clk); #1; c++; end while (!ws && c < 500);
    chk("t6_ws_high", 32'(ws), 32'h1);
    rst = 1'b1;
    #1;
    chk("t6_rst_pins", {29'b0, sck, ws, sd}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    rd_chk("t6_status", 32'hC, st(0, 1'b0));
    rd_chk("t6_ctrl", 32'h0, 32'h0);
    rd_chk("t6_clkdiv", 32'h4, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
